cal_abs_angle_arb: RTL and testbench
====================================

// Module: cal_abs_angle_arb
// PURPOSE
//   Shares one cal_abs_angle engine (fixed 7-clk latency, no stall input) between N_CH
//   sample streams. Packet-level round-robin: a granted channel owns the engine until its
//   'last' beat is accepted. A LAT-deep tag pipeline routes each engine result back to its
//   source channel with its packet boundary. Sits between the per-channel sample sources and
//   the downstream abs/angle consumers.
// PARAMETERS
//   N_CH   4   number of requesting channels (2..8)
//   CH_W   2   channel-id width, clog2(N_CH)
//   LAT    7   engine latency from val_i to val_o, in clk cycles
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        synchronous reset, active low
//   s_valid      in   N_CH     per-channel sample valid
//   s_ready      out  N_CH     per-channel accept; at most one bit high
//   s_last       in   N_CH     per-channel last sample of packet
//   s_real       in   8*N_CH   per-channel real part; ch k at [8k+7:8k]
//   s_imag       in   8*N_CH   per-channel imag part; same packing
//   eng_val      out  1        to engine val_i
//   eng_real     out  8        to engine real_i
//   eng_imag     out  8        to engine imag_i
//   eng_val_r    in   1        from engine val_o
//   eng_abs      in   8        from engine abs_o
//   eng_angle    in   16       from engine angle_o
//   m_valid      out  N_CH     one-hot result strobe; no back-pressure
//   m_last       out  1        result is the last of its packet
//   m_ch         out  CH_W     channel id of current result
//   m_abs        out  8        magnitude
//   m_angle      out  16       angle
//   err_sync     out  1        sticky: eng_val_r disagreed with tag pipeline
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): all outputs 0; FSM=IDLE; rr_ptr=0; tag pipe all invalid;
//     blank counter=LAT.
//   FSM IDLE: s_ready=0. If any s_valid: grant = first set s_valid at/after rr_ptr
//     (cyclic). Register gnt, go BURST next cycle. Else stay.
//   FSM BURST: s_ready[gnt]=s_valid[gnt] (combinational from state, not from s_valid of
//     other channels). Beat accepted when s_valid[gnt]&s_ready[gnt]. Accepted beat with
//     s_last -> IDLE, rr_ptr=gnt+1 mod N_CH. Gaps (s_valid low) hold the grant.
//   Engine drive: registered; eng_val=accept, eng_real/imag=accepted data, held otherwise.
//   Tag pipe: LAT stages of {valid,ch,last}, stage0 loaded in the same cycle as eng_val.
//   Result: registered one cycle after eng_val_r with tag[LAT-1]. m_valid[ch]=1,
//     m_ch/m_last/m_abs/m_angle valid for that cycle; m_abs/m_angle/m_ch hold otherwise.
//   Latency: accept edge -> m_valid = LAT+2 cycles (9 at default). Throughput 1 beat/clk
//     within a packet; 1 idle cycle between packets (IDLE arbitration).
//   Order: results leave in acceptance order; packets never interleave.
//   err_sync: set when eng_val_r != tag[LAT-1].valid, except while blank counter != 0;
//     cleared only by reset. On mismatch result dropped (m_valid stays 0).
//   Reset mid-packet: packet abandoned, in-flight results from before reset are dropped
//     (tags invalid), blank counter (LAT cycles) suppresses err_sync for them.
//   Single requester: regranted after its last beat with one IDLE cycle between packets.
//   1-beat packet (s_valid&s_last on first beat): BURST lasts exactly 1 cycle.
// STRUCTURE
//   Package cal_abs_angle_pkg: LAT=7, ABS_W=8, ANGLE_W=16, IQ_W=8, fsm enum {IDLE,BURST}.
//   Sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot, id, any).
//   Engine instantiated outside this block; connected via eng_* ports.
// TESTING
//   Ch1 only, 4-beat packet (1,2),(3,4),(5,6),(7,8) -> m_valid[1] 9 clks after each accept,
//     m_last on beat 4, m_abs/m_angle equal reference engine model.
//   Ch0,ch2 both request, rr_ptr=0, 3-beat packets -> ch0 packet fully, 1 idle clk, then ch2;
//     m_ch sequence 0,0,0,2,2,2.
//   All 4 ch continuously requesting 1-beat packets -> grants 0,1,2,3,0 every 2 clks.
//   Ch3 packet with s_valid gaps (on,off,off,on+last) -> no other grant until last; 2 results.
//   rst_n low 1 clk mid-packet with 5 beats in flight -> no m_valid for them, err_sync=0.
//   Force eng_val_r high with empty tag pipe after blanking -> err_sync=1, no m_valid.

Source files
------------

// File: rtl/cal_abs_angle_pkg.sv
// ----------------------------------------------------------------------------
// cal_abs_angle_pkg
//   Shared constants and types for the cal_abs_angle engine arbiter.
//   LAT      engine latency (val_i -> val_o) in clock cycles
//   ABS_W    magnitude width
//   ANGLE_W  angle width
//   IQ_W     width of one real/imag sample component
//   fsm_e    arbiter state: IDLE (arbitrating) / BURST (channel owns engine)
// ----------------------------------------------------------------------------
package cal_abs_angle_pkg;

    localparam int LAT     = 7;
    localparam int ABS_W   = 8;
    localparam int ANGLE_W = 16;
    localparam int IQ_W    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } fsm_e;

endpackage

// File: rtl/cal_abs_angle_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request at or
//   after ptr_i, wrapping cyclically through N_CH channels.
//   req_i     per-channel request vector
//   ptr_i     channel with highest priority this round
//   gnt_oh_o  one-hot winner (all zero when nothing requests)
//   gnt_id_o  binary id of the winner
//   any_o     at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N_CH-1:0] gnt_oh_o,
    output logic [CH_W-1:0] gnt_id_o,
    output logic            any_o
);

    logic found_s;
    logic hit_s;
    int   idx_s;

    // Walk the channels starting at ptr_i; only the first hit is latched.
    always_comb begin
        found_s  = 1'b0;
        hit_s    = 1'b0;
        idx_s    = 0;
        gnt_oh_o = {N_CH{1'b0}};
        gnt_id_o = {CH_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            idx_s           = (int'(ptr_i) + i) % N_CH;
            hit_s           = req_i[idx_s] & ~found_s;
            gnt_oh_o[idx_s] = gnt_oh_o[idx_s] | hit_s;
            gnt_id_o        = hit_s ? CH_W'(idx_s) : gnt_id_o;
            found_s         = found_s | hit_s;
        end
        any_o = found_s;
    end

endmodule

// File: rtl/cal_abs_angle_arb.sv
// ----------------------------------------------------------------------------
// cal_abs_angle_arb
//   Shares one fixed-latency cal_abs_angle engine between N_CH sample streams.
//   Packet-level round-robin: the granted channel keeps the engine until its
//   last beat is accepted. A LAT-deep tag pipeline carries {valid,ch,last}
//   alongside the engine so each result is routed back to its source channel.
//   clk, rst_n             clock, synchronous active-low reset
//   s_valid/s_ready/s_last per-channel sample handshake and packet end
//   s_real/s_imag          per-channel samples, ch k at [8k+7:8k]
//   eng_val/real/imag      registered drive to the engine
//   eng_val_r/abs/angle    engine results
//   m_valid (one-hot), m_last, m_ch, m_abs, m_angle   routed result
//   err_sync               sticky: engine valid disagreed with tag pipeline
// ----------------------------------------------------------------------------
module cal_abs_angle_arb #(
    parameter int N_CH = 4,
    parameter int CH_W = 2,
    parameter int LAT  = cal_abs_angle_pkg::LAT
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_CH-1:0]                        s_valid,
    output logic [N_CH-1:0]                        s_ready,
    input  logic [N_CH-1:0]                        s_last,
    input  logic [cal_abs_angle_pkg::IQ_W*N_CH-1:0] s_real,
    input  logic [cal_abs_angle_pkg::IQ_W*N_CH-1:0] s_imag,
    output logic                                   eng_val,
    output logic [cal_abs_angle_pkg::IQ_W-1:0]     eng_real,
    output logic [cal_abs_angle_pkg::IQ_W-1:0]     eng_imag,
    input  logic                                   eng_val_r,
    input  logic [cal_abs_angle_pkg::ABS_W-1:0]    eng_abs,
    input  logic [cal_abs_angle_pkg::ANGLE_W-1:0]  eng_angle,
    output logic [N_CH-1:0]                        m_valid,
    output logic                                   m_last,
    output logic [CH_W-1:0]                        m_ch,
    output logic [cal_abs_angle_pkg::ABS_W-1:0]    m_abs,
    output logic [cal_abs_angle_pkg::ANGLE_W-1:0]  m_angle,
    output logic                                   err_sync
);

    import cal_abs_angle_pkg::*;

    localparam int CNT_W = $clog2(LAT + 1);

    fsm_e               state_q, state_d;
    logic [CH_W-1:0]    gnt_q, gnt_d;
    logic [N_CH-1:0]    gnt_oh_q, gnt_oh_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [N_CH-1:0]    pick_oh_s;
    logic [CH_W-1:0]    pick_id_s;
    logic               pick_any_s;

    logic [N_CH-1:0]    s_ready_s;
    logic               accept_s;
    logic               acc_last_s;
    logic [IQ_W-1:0]    acc_real_s, acc_imag_s;

    logic               eng_val_q;
    logic [IQ_W-1:0]    eng_real_q, eng_imag_q;
    logic [CH_W-1:0]    eng_ch_q;
    logic               eng_last_q;

    logic [LAT-1:0]     tag_vld_q;
    logic [LAT-1:0]     tag_last_q;
    logic [CH_W-1:0]    tag_ch_q [LAT];
    logic [CNT_W-1:0]   blank_q;

    logic               fire_s, mismatch_s;
    logic [N_CH-1:0]    m_valid_d;
    logic [N_CH-1:0]    m_valid_q;
    logic               m_last_q;
    logic [CH_W-1:0]    m_ch_q;
    logic [ABS_W-1:0]   m_abs_q;
    logic [ANGLE_W-1:0] m_angle_q;
    logic               err_q;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_pick (
        .req_i    (s_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_oh_o (pick_oh_s),
        .gnt_id_o (pick_id_s),
        .any_o    (pick_any_s)
    );

    // Only the granted channel sees ready, and only while the FSM owns a burst.
    always_comb begin
        if (state_q == BURST) begin
            s_ready_s = gnt_oh_q & s_valid;
        end else begin
            s_ready_s = {N_CH{1'b0}};
        end
    end

    assign accept_s   = |s_ready_s;
    assign acc_last_s = s_last[gnt_q];
    assign acc_real_s = s_real[IQ_W*int'(gnt_q) +: IQ_W];
    assign acc_imag_s = s_imag[IQ_W*int'(gnt_q) +: IQ_W];

    // Arbitration FSM: grant in IDLE, release after the accepted last beat.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d  = BURST;
                    gnt_d    = pick_id_s;
                    gnt_oh_d = pick_oh_s;
                end else begin
                    state_d  = IDLE;
                end
            end
            BURST: begin
                if (accept_s && acc_last_s) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == CH_W'(N_CH - 1)) ? {CH_W{1'b0}}
                                                          : gnt_q + CH_W'(1);
                end else begin
                    state_d  = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= {CH_W{1'b0}};
            gnt_oh_q <= {N_CH{1'b0}};
            rr_ptr_q <= {CH_W{1'b0}};
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Engine drive: data and its routing tag are captured together on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_val_q  <= 1'b0;
            eng_real_q <= {IQ_W{1'b0}};
            eng_imag_q <= {IQ_W{1'b0}};
            eng_ch_q   <= {CH_W{1'b0}};
            eng_last_q <= 1'b0;
        end else begin
            eng_val_q <= accept_s;
            if (accept_s) begin
                eng_real_q <= acc_real_s;
                eng_imag_q <= acc_imag_s;
                eng_ch_q   <= gnt_q;
                eng_last_q <= acc_last_s;
            end else begin
                eng_real_q <= eng_real_q;
                eng_imag_q <= eng_imag_q;
                eng_ch_q   <= eng_ch_q;
                eng_last_q <= eng_last_q;
            end
        end
    end

    // Tag pipeline: stage 0 samples the engine drive as the engine does, so
    // stage LAT-1 lines up with eng_val_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_q  <= {LAT{1'b0}};
            tag_last_q <= {LAT{1'b0}};
            for (int k = 0; k < LAT; k++) begin
                tag_ch_q[k] <= {CH_W{1'b0}};
            end
        end else begin
            tag_vld_q  <= {tag_vld_q[LAT-2:0], eng_val_q};
            tag_last_q <= {tag_last_q[LAT-2:0], eng_last_q};
            tag_ch_q[0] <= eng_ch_q;
            for (int k = 1; k < LAT; k++) begin
                tag_ch_q[k] <= tag_ch_q[k-1];
            end
        end
    end

    // Results the engine was already computing at reset have no tags; the
    // blank counter masks the sync check until they have drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= CNT_W'(LAT);
        end else if (blank_q != {CNT_W{1'b0}}) begin
            blank_q <= blank_q - CNT_W'(1);
        end else begin
            blank_q <= blank_q;
        end
    end

    assign fire_s     = eng_val_r & tag_vld_q[LAT-1];
    assign mismatch_s = (eng_val_r != tag_vld_q[LAT-1]) &&
                        (blank_q == {CNT_W{1'b0}});

    // One-hot strobe for the channel named by the oldest tag.
    always_comb begin
        m_valid_d = {N_CH{1'b0}};
        if (fire_s) begin
            m_valid_d[tag_ch_q[LAT-1]] = 1'b1;
        end else begin
            m_valid_d = {N_CH{1'b0}};
        end
    end

    // Result register and sticky sync error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= {N_CH{1'b0}};
            m_last_q  <= 1'b0;
            m_ch_q    <= {CH_W{1'b0}};
            m_abs_q   <= {ABS_W{1'b0}};
            m_angle_q <= {ANGLE_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            err_q     <= err_q | mismatch_s;
            if (fire_s) begin
                m_last_q  <= tag_last_q[LAT-1];
                m_ch_q    <= tag_ch_q[LAT-1];
                m_abs_q   <= eng_abs;
                m_angle_q <= eng_angle;
            end else begin
                m_last_q  <= 1'b0;
                m_ch_q    <= m_ch_q;
                m_abs_q   <= m_abs_q;
                m_angle_q <= m_angle_q;
            end
        end
    end

    assign s_ready  = s_ready_s;
    assign eng_val  = eng_val_q;
    assign eng_real = eng_real_q;
    assign eng_imag = eng_imag_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_ch     = m_ch_q;
    assign m_abs    = m_abs_q;
    assign m_angle  = m_angle_q;
    assign err_sync = err_q;

endmodule

// File: tb/tb_cal_abs_angle_arb.sv
// ----------------------------------------------------------------------------
// tb_cal_abs_angle_arb
//   Directed bench for cal_abs_angle_arb with a 7-stage reference engine.
//   The reference engine computes abs = real+imag, angle = {real,imag}^5A5A.
// ----------------------------------------------------------------------------
module tb_cal_abs_angle_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_valid = 4'b0;
    logic [3:0]  s_ready;
    logic [3:0]  s_last = 4'b0;
    logic [31:0] s_real = 32'b0;
    logic [31:0] s_imag = 32'b0;
    logic        eng_val;
    logic [7:0]  eng_real, eng_imag;
    logic        eng_val_r;
    logic [7:0]  eng_abs;
    logic [15:0] eng_angle;
    logic [3:0]  m_valid;
    logic        m_last;
    logic [1:0]  m_ch;
    logic [7:0]  m_abs;
    logic [15:0] m_angle;
    logic        err_sync;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    cal_abs_angle_arb #(.N_CH(4), .CH_W(2), .LAT(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .s_real    (s_real),
        .s_imag    (s_imag),
        .eng_val   (eng_val),
        .eng_real  (eng_real),
        .eng_imag  (eng_imag),
        .eng_val_r (eng_val_r),
        .eng_abs   (eng_abs),
        .eng_angle (eng_angle),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ch      (m_ch),
        .m_abs     (m_abs),
        .m_angle   (m_angle),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference engine: 7-cycle pipeline, not reset (lives outside the DUT).
    logic [6:0]  pv = 7'b0;
    logic [7:0]  pa [7];
    logic [15:0] pg [7];
    logic        force_val = 1'b0;
    always @(posedge clk) begin
        pv    <= {pv[5:0], eng_val};
        pa[0] <= eng_real + eng_imag;
        pg[0] <= {eng_real, eng_imag} ^ 16'h5A5A;
        for (int k = 1; k < 7; k++) begin
            pa[k] <= pa[k-1];
            pg[k] <= pg[k-1];
        end
    end
    assign eng_val_r = pv[6] | force_val;
    assign eng_abs   = pa[6];
    assign eng_angle = pg[6];

    // Monitor: log accepted beats and results with their cycle numbers.
    typedef struct { int cyc; int ch; logic last; } acc_t;
    typedef struct { int cyc; logic [3:0] v; int ch; logic last; logic [7:0] abs_v; logic [15:0] ang; } res_t;
    acc_t acc_q [$];
    res_t res_q [$];
    always @(negedge clk) begin
        res_t r;
        acc_t a;
        if (m_valid != 4'b0) begin
            r.cyc = cyc; r.v = m_valid; r.ch = int'(m_ch); r.last = m_last;
            r.abs_v = m_abs; r.ang = m_angle;
            res_q.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            if (rst_n && s_valid[k] && s_ready[k]) begin
                a.cyc = cyc; a.ch = k; a.last = s_last[k];
                acc_q.push_back(a);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 4'b0; s_last = 4'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic set_beat(input int ch, input logic v, input logic l, input logic [7:0] re, input logic [7:0] im);
        s_valid[ch] = v;
        s_last[ch]  = l;
        s_real[8*ch +: 8] = re;
        s_imag[8*ch +: 8] = im;
    endtask

    task automatic wait_rdy(input int ch, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready[ch] && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(s_ready[ch]), 32'h1);
    endtask

    // Per-channel beat plan for the multi-channel driver.
    int         len [4];
    int         idx [4];
    logic [7:0] bre [4][8];
    logic [7:0] bim [4][8];
    logic       blast [4][8];

    task automatic clear_plan();
        for (int c = 0; c < 4; c++) begin
            len[c] = 0; idx[c] = 0;
            for (int b = 0; b < 8; b++) begin
                bre[c][b] = 8'd0; bim[c][b] = 8'd0; blast[c][b] = 1'b0;
            end
        end
    endtask

    // Each channel presents its next beat until it is accepted.
    task automatic run(input int ncyc);
        logic [3:0] accd;
        accd = 4'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            for (int ch = 0; ch < 4; ch++) begin
                if (accd[ch]) idx[ch]++;
                if (idx[ch] < len[ch]) set_beat(ch, 1'b1, blast[ch][idx[ch]], bre[ch][idx[ch]], bim[ch][idx[ch]]);
                else set_beat(ch, 1'b0, 1'b0, 8'd0, 8'd0);
            end
            @(negedge clk);
            accd = s_valid & s_ready;
        end
        tick();
        s_valid = 4'b0; s_last = 4'b0;
    endtask

    logic [7:0]  t1_abs [4];
    logic [15:0] t1_ang [4];
    int          t2_ch  [6];
    logic        t2_last[6];
    int ab, rb, n_acc;

    initial begin
        t1_abs = '{8'd3, 8'd7, 8'd11, 8'd15};
        t1_ang = '{16'h5B58, 16'h595E, 16'h5F5C, 16'h5D52};
        t2_ch   = '{0, 0, 0, 2, 2, 2};
        t2_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_eng_val", 32'(eng_val), 32'h0);
        chk("rst_err",     32'(err_sync), 32'h0);
        chk("rst_m_abs",   32'(m_abs), 32'h0);
        chk("rst_m_angle", 32'(m_angle), 32'h0);

        // Test 1: ch1 alone, 4-beat packet
        clear_plan();
        len[1] = 4;
        bre[1][0] = 8'd1; bim[1][0] = 8'd2;
        bre[1][1] = 8'd3; bim[1][1] = 8'd4;
        bre[1][2] = 8'd5; bim[1][2] = 8'd6;
        bre[1][3] = 8'd7; bim[1][3] = 8'd8;
        blast[1][3] = 1'b1;
        ab = acc_q.size(); rb = res_q.size();
        run(20);
        chk("t1_acc_n", 32'(acc_q.size() - ab), 32'd4);
        chk("t1_res_n", 32'(res_q.size() - rb), 32'd4);
        if (acc_q.size() - ab >= 4 && res_q.size() - rb >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t1_lat%0d", i),  32'(res_q[rb+i].cyc - acc_q[ab+i].cyc), 32'd9);
                chk($sformatf("t1_acc_cyc%0d", i), 32'(acc_q[ab+i].cyc - acc_q[ab].cyc), 32'(i));
                chk($sformatf("t1_v%0d", i),    32'(res_q[rb+i].v), 32'h2);
                chk($sformatf("t1_ch%0d", i),   32'(res_q[rb+i].ch), 32'd1);
                chk($sformatf("t1_last%0d", i), 32'(res_q[rb+i].last), (i == 3) ? 32'd1 : 32'd0);
                chk($sformatf("t1_abs%0d", i),  32'(res_q[rb+i].abs_v), 32'(t1_abs[i]));
                chk($sformatf("t1_ang%0d", i),  32'(res_q[rb+i].ang), 32'(t1_ang[i]));
            end
        end

        // Test 2: ch0 and ch2 compete from rr_ptr=0, 3-beat packets
        do_reset();
        clear_plan();
        len[0] = 3; len[2] = 3;
        for (int b = 0; b < 3; b++) begin
            bre[0][b] = 8'(10 + b); bim[0][b] = 8'd1;
            bre[2][b] = 8'(20 + b); bim[2][b] = 8'd2;
        end
        blast[0][2] = 1'b1; blast[2][2] = 1'b1;
        ab = acc_q.size(); rb = res_q.size();
        run(24);
        chk("t2_acc_n", 32'(acc_q.size() - ab), 32'd6);
        chk("t2_res_n", 32'(res_q.size() - rb), 32'd6);
        if (acc_q.size() - ab >= 6 && res_q.size() - rb >= 6) begin
            chk("t2_back2back", 32'(acc_q[ab+1].cyc - acc_q[ab].cyc), 32'd1);
            chk("t2_idle_gap",  32'(acc_q[ab+3].cyc - acc_q[ab+2].cyc), 32'd2);
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t2_ch%0d", i),   32'(res_q[rb+i].ch), 32'(t2_ch[i]));
                chk($sformatf("t2_last%0d", i), 32'(res_q[rb+i].last), 32'(t2_last[i]));
            end
            chk("t2_abs3", 32'(res_q[rb+3].abs_v), 32'd22);
            chk("t2_v3",   32'(res_q[rb+3].v), 32'h4);
        end

        // Test 3: all channels streaming 1-beat packets
        do_reset();
        clear_plan();
        for (int c = 0; c < 4; c++) begin
            len[c] = 2;
            for (int b = 0; b < 2; b++) begin
                bre[c][b] = 8'(16*c + b); bim[c][b] = 8'd0; blast[c][b] = 1'b1;
            end
        end
        ab = acc_q.size(); rb = res_q.size();
        run(30);
        chk("t3_acc_n", 32'(acc_q.size() - ab), 32'd8);
        chk("t3_res_n", 32'(res_q.size() - rb), 32'd8);
        if (acc_q.size() - ab >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t3_gnt%0d", i), 32'(acc_q[ab+i].ch), 32'(i % 4));
                if (i > 0) chk($sformatf("t3_space%0d", i), 32'(acc_q[ab+i].cyc - acc_q[ab+i-1].cyc), 32'd2);
            end
        end

        // Test 4: ch3 packet with gaps while ch0 waits
        ab = acc_q.size(); rb = res_q.size();
        set_beat(3, 1'b1, 1'b0, 8'd9, 8'd1);
        wait_rdy(3, "t4_first_rdy");
        tick();
        set_beat(3, 1'b0, 1'b0, 8'd0, 8'd0);
        set_beat(0, 1'b1, 1'b1, 8'd4, 8'd4);
        @(negedge clk);
        chk("t4_gap1_rdy", 32'(s_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("t4_gap2_rdy", 32'(s_ready), 32'h0);
        tick();
        set_beat(3, 1'b1, 1'b1, 8'd2, 8'd2);
        @(negedge clk);
        chk("t4_last_rdy", 32'(s_ready), 32'h8);
        tick();
        set_beat(3, 1'b0, 1'b0, 8'd0, 8'd0);
        wait_rdy(0, "t4_ch0_rdy");
        tick();
        set_beat(0, 1'b0, 1'b0, 8'd0, 8'd0);
        repeat (14) tick();
        chk("t4_res_n", 32'(res_q.size() - rb), 32'd3);
        if (res_q.size() - rb >= 3 && acc_q.size() - ab >= 3) begin
            chk("t4_acc_ch2", 32'(acc_q[ab+2].ch), 32'd0);
            chk("t4_ch0",   32'(res_q[rb].ch), 32'd3);
            chk("t4_last0", 32'(res_q[rb].last), 32'd0);
            chk("t4_abs0",  32'(res_q[rb].abs_v), 32'd10);
            chk("t4_ch1",   32'(res_q[rb+1].ch), 32'd3);
            chk("t4_last1", 32'(res_q[rb+1].last), 32'd1);
            chk("t4_abs1",  32'(res_q[rb+1].abs_v), 32'd4);
            chk("t4_ch2",   32'(res_q[rb+2].ch), 32'd0);
            chk("t4_abs2",  32'(res_q[rb+2].abs_v), 32'd8);
        end

        // Test 5: reset mid-packet with 5 beats in flight
        rb = res_q.size();
        n_acc = 0;
        set_beat(1, 1'b1, 1'b0, 8'd1, 8'd1);
        for (int k = 0; k < 20 && n_acc < 5; k++) begin
            @(negedge clk);
            if (s_ready[1]) n_acc++;
            tick();
            set_beat(1, 1'b1, 1'b0, 8'(k + 2), 8'd1);
        end
        chk("t5_acc5", 32'(n_acc), 32'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_beat(1, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t5_rst_eng_val", 32'(eng_val), 32'h0);
        chk("t5_rst_s_ready", 32'(s_ready), 32'h0);
        repeat (16) tick();
        chk("t5_no_res", 32'(res_q.size() - rb), 32'd0);
        chk("t5_err",    32'(err_sync), 32'h0);

        // Test 6: spurious engine valid with empty tag pipe
        rb = res_q.size();
        force_val = 1'b1;
        tick();
        force_val = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 32'(err_sync), 32'h1);
        chk("t6_no_valid", 32'(m_valid), 32'h0);
        repeat (3) tick();
        chk("t6_err_sticky", 32'(err_sync), 32'h1);
        chk("t6_no_res", 32'(res_q.size() - rb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
